// File: rtl/gp_txn_ctrl.sv
// Transaction controller: IDLE -> GET1 -> GET2 -> WAIT, counting consumer puts; optional watchdog via GP_TXN_CTRL_WATCHDOG_EN.
// Latency: get rises the cycle after go is accepted; done/aborted/timeout pulse the cycle after the deciding input.
// Backpressure: none; put is a one-cycle handshake counted in GET2/WAIT, stop aborts from any active state.
module gp_txn_ctrl #(
   parameter int unsigned NPUT     = 2,
   parameter int unsigned MAX_WAIT = 31
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       go,
   input  logic       stop,
   input  logic       put,
   output logic       get,
   output logic       busy,
   output logic       done,
   output logic       aborted,
   output logic       timeout,
   output logic [3:0] put_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GET1 = 2'd1,
      ST_GET2 = 2'd2,
      ST_WAIT = 2'd3
   } state_t;

   localparam logic [3:0] NPUT_W  = 4'(NPUT);
   localparam logic [3:0] NPUT_M1 = 4'(NPUT - 1);

   state_t     state_q, state_d;
   logic       get_q, get_d;
   logic       done_q, done_d;
   logic       aborted_q, aborted_d;
   logic [3:0] put_cnt_q, put_cnt_d;

`ifdef GP_TXN_CTRL_WATCHDOG_EN
   logic [7:0] wd_q, wd_d;
   logic       timeout_q, timeout_d;
   logic       wd_exp;

   // wd_q is 0 on the first GET2 cycle, so MAX_WAIT-1 marks the last allowed cycle
   assign wd_exp = (wd_q == 8'(MAX_WAIT - 1));
`endif

   always_comb begin
      state_d   = state_q;
      done_d    = 1'b0;
      aborted_d = 1'b0;
      put_cnt_d = put_cnt_q;
`ifdef GP_TXN_CTRL_WATCHDOG_EN
      wd_d      = wd_q;
      timeout_d = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (go && !stop) begin
               state_d   = ST_GET1;
               put_cnt_d = 4'd0;
`ifdef GP_TXN_CTRL_WATCHDOG_EN
               wd_d      = 8'd0;
`endif
            end
         end
         ST_GET1: begin
            if (stop) begin
               state_d   = ST_IDLE;
               aborted_d = 1'b1;
            end else begin
               state_d = ST_GET2;
            end
         end
         ST_GET2, ST_WAIT: begin
            if (put && (put_cnt_q < NPUT_W)) begin
               put_cnt_d = put_cnt_q + 4'd1;
            end
`ifdef GP_TXN_CTRL_WATCHDOG_EN
            wd_d = wd_q + 8'd1;
`endif
            // Priority: stop, then completion, then watchdog expiry
            if (stop) begin
               state_d   = ST_IDLE;
               aborted_d = 1'b1;
            end else if (put && (put_cnt_q == NPUT_M1)) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
`ifdef GP_TXN_CTRL_WATCHDOG_EN
            else if (wd_exp) begin
               state_d   = ST_IDLE;
               timeout_d = 1'b1;
            end
`endif
            else begin
               state_d = ST_WAIT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      get_d = (state_d == ST_GET1) || (state_d == ST_GET2);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         get_q     <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         put_cnt_q <= 4'd0;
      end else begin
         state_q   <= state_d;
         get_q     <= get_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
         put_cnt_q <= put_cnt_d;
      end
   end

`ifdef GP_TXN_CTRL_WATCHDOG_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_q      <= 8'd0;
         timeout_q <= 1'b0;
      end else begin
         wd_q      <= wd_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

   assign get     = get_q;
   assign busy    = (state_q != ST_IDLE);
   assign done    = done_q;
   assign aborted = aborted_q;
   assign put_cnt = put_cnt_q;

endmodule

// File: tb/tb_gp_txn_ctrl.sv
// Bench for gp_txn_ctrl: directed scenarios plus randomized traffic checked against a transaction-age model.
module tb_gp_txn_ctrl;

   localparam int NPUT     = 2;
   localparam int MAX_WAIT = 8;
`ifdef GP_TXN_CTRL_WATCHDOG_EN
   localparam bit WD_EN = 1'b1;
`else
   localparam bit WD_EN = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic       go, stop, put;
   logic       get, busy, done, aborted, timeout;
   logic [3:0] put_cnt;

   gp_txn_ctrl #(.NPUT(NPUT), .MAX_WAIT(MAX_WAIT)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .go      (go),
      .stop    (stop),
      .put     (put),
      .get     (get),
      .busy    (busy),
      .done    (done),
      .aborted (aborted),
      .timeout (timeout),
      .put_cnt (put_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   // Reference model: a transaction is described by the cycle go was accepted and puts seen so far
   bit   m_active;
   int   m_start;
   int   m_cnt;
   logic exp_get, exp_busy, exp_done, exp_abort, exp_to;
   logic [3:0] exp_cnt;

   logic in_go [0:127];
   logic in_stop [0:127];
   logic in_put [0:127];
   logic o_get [0:127];
   logic o_busy [0:127];
   logic o_done [0:127];
   logic o_abort [0:127];
   logic o_to [0:127];
   logic [3:0] o_cnt [0:127];

   task automatic model_reset();
      m_active = 1'b0;
      m_start  = 0;
      m_cnt    = 0;
   endtask

   task automatic model_cycle(input logic g, input logic s, input logic p);
      int age;
      exp_done  = 1'b0;
      exp_abort = 1'b0;
      exp_to    = 1'b0;
      if (!m_active) begin
         if (g && !s) begin
            m_active = 1'b1;
            m_start  = cyc;
            m_cnt    = 0;
         end
      end else begin
         age = cyc - m_start;
         if (age >= 2 && p && m_cnt < NPUT) m_cnt++;
         if (s) begin
            exp_abort = 1'b1;
            m_active  = 1'b0;
         end else if (age >= 2 && p && m_cnt == NPUT) begin
            exp_done = 1'b1;
            m_active = 1'b0;
         end else if (WD_EN && age >= 2 && (age - 2) == MAX_WAIT - 1) begin
            exp_to   = 1'b1;
            m_active = 1'b0;
         end
      end
      exp_busy = m_active;
      exp_get  = m_active && ((cyc + 1 - m_start) <= 2);
      exp_cnt  = 4'(m_cnt);
   endtask

   // Drive inputs for the current cycle, advance one clock, land #1 after the edge
   task automatic step(input logic g, input logic s, input logic p);
      go   = g;
      stop = s;
      put  = p;
      model_cycle(g, s, p);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      go    = 1'b0;
      stop  = 1'b0;
      put   = 1'b0;
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic clear_inputs();
      for (int i = 0; i < 128; i++) begin
         in_go[i]   = 1'b0;
         in_stop[i] = 1'b0;
         in_put[i]  = 1'b0;
      end
   endtask

   task automatic run(input int last);
      cyc = 10;
      for (int c = 10; c <= last; c++) begin
         step(in_go[c], in_stop[c], in_put[c]);
         o_get[c+1]   = get;
         o_busy[c+1]  = busy;
         o_done[c+1]  = done;
         o_abort[c+1] = aborted;
         o_to[c+1]    = timeout;
         o_cnt[c+1]   = put_cnt;
      end
      go   = 1'b0;
      stop = 1'b0;
      put  = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      go    = 1'b1;
      stop  = 1'b0;
      put   = 1'b1;
      #3;
      n_chk++;
      if ({get, busy, done, aborted, timeout, put_cnt} !== 9'd0)
         $display("FAIL reset_outputs: got %b want 000000000", {get, busy, done, aborted, timeout, put_cnt});
      else n_pass++;
      repeat (2) @(posedge clk);
      #1;
      n_chk++;
      if ({get, busy, put_cnt} !== 6'd0)
         $display("FAIL reset_held: got %b want 000000", {get, busy, put_cnt});
      else n_pass++;
      do_reset();
   endtask

   task automatic test_basic();
      bit bad;
      do_reset();
      clear_inputs();
      in_go[10]  = 1'b1;
      in_put[13] = 1'b1;
      in_put[15] = 1'b1;
      run(17);
      n_chk++;
      if ({o_get[11], o_get[12], o_get[13]} !== 3'b110)
         $display("FAIL basic_get: got %b want 110", {o_get[11], o_get[12], o_get[13]});
      else n_pass++;
      n_chk++;
      if ({o_done[15], o_done[16], o_done[17]} !== 3'b010)
         $display("FAIL basic_done: got %b want 010", {o_done[15], o_done[16], o_done[17]});
      else n_pass++;
      n_chk++;
      if (o_cnt[16] !== 4'd2) $display("FAIL basic_put_cnt: got %0d want 2", o_cnt[16]);
      else n_pass++;
      bad = 1'b0;
      for (int c = 11; c <= 15; c++) if (o_busy[c] !== 1'b1) bad = 1'b1;
      n_chk++;
      if (bad || o_busy[16] !== 1'b0)
         $display("FAIL basic_busy: window_bad=%0d busy16=%b want 0/0", bad, o_busy[16]);
      else n_pass++;
   endtask

   task automatic test_idle_inputs();
      // Follows test_basic: IDLE holding put_cnt=2
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      n_chk++;
      if ({busy, put_cnt} !== {1'b0, 4'd2})
         $display("FAIL idle_hold: got busy=%b cnt=%0d want busy=0 cnt=2", busy, put_cnt);
      else n_pass++;
      step(1'b1, 1'b1, 1'b0);
      n_chk++;
      if ({busy, get} !== 2'b00)
         $display("FAIL idle_go_stop: got busy,get=%b want 00", {busy, get});
      else n_pass++;
   endtask

   task automatic test_abort();
      bit any_done;
      do_reset();
      clear_inputs();
      in_go[10]   = 1'b1;
      in_put[12]  = 1'b1;
      in_stop[14] = 1'b1;
      run(18);
      any_done = 1'b0;
      for (int c = 11; c <= 19; c++) if (o_done[c] !== 1'b0) any_done = 1'b1;
      n_chk++;
      if ({o_abort[14], o_abort[15], o_abort[16]} !== 3'b010)
         $display("FAIL abort_pulse: got %b want 010", {o_abort[14], o_abort[15], o_abort[16]});
      else n_pass++;
      n_chk++;
      if (any_done !== 1'b0 || o_cnt[15] !== 4'd1 || o_busy[15] !== 1'b0)
         $display("FAIL abort_state: done_seen=%0d cnt=%0d busy=%b want 0/1/0", any_done, o_cnt[15], o_busy[15]);
      else n_pass++;
   endtask

   task automatic test_stop_priority();
      do_reset();
      clear_inputs();
      in_go[10]   = 1'b1;
      in_put[13]  = 1'b1;
      in_put[16]  = 1'b1;
      in_stop[16] = 1'b1;
      run(18);
      n_chk++;
      if ({o_abort[17], o_done[17], o_to[17], o_busy[17]} !== 4'b1000)
         $display("FAIL stop_priority: got abort,done,to,busy=%b want 1000",
                  {o_abort[17], o_done[17], o_to[17], o_busy[17]});
      else n_pass++;
   endtask

   task automatic test_watchdog();
      bit busy_gap, to_seen;
      do_reset();
      clear_inputs();
      in_go[10]  = 1'b1;
      in_put[11] = 1'b1;
      run(100);
      n_chk++;
      if (o_cnt[13] !== 4'd0) $display("FAIL wd_get1_put: got cnt=%0d want 0", o_cnt[13]);
      else n_pass++;
      if (WD_EN) begin
         n_chk++;
         if ({o_to[19], o_to[20], o_to[21], o_busy[19], o_busy[20]} !== 5'b01010)
            $display("FAIL wd_timeout: got to19,20,21,busy19,20=%b want 01010",
                     {o_to[19], o_to[20], o_to[21], o_busy[19], o_busy[20]});
         else n_pass++;
      end else begin
         busy_gap = 1'b0;
         to_seen  = 1'b0;
         for (int c = 11; c <= 100; c++) begin
            if (o_busy[c] !== 1'b1) busy_gap = 1'b1;
            if (o_to[c] !== 1'b0) to_seen = 1'b1;
         end
         n_chk++;
         if (busy_gap || to_seen)
            $display("FAIL wd_off_persist: busy_gap=%0d timeout_seen=%0d want 0/0", busy_gap, to_seen);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      clear_inputs();
      in_go[10] = 1'b1;
      run(12);
      n_chk++;
      if (busy !== 1'b1) $display("FAIL rst_mid_pre: got busy=%b want 1", busy);
      else n_pass++;
      rst_n = 1'b0;
      model_reset();
      #1;
      n_chk++;
      if ({get, busy, done, aborted, timeout, put_cnt} !== 9'd0)
         $display("FAIL rst_mid_async: got %b want 000000000", {get, busy, done, aborted, timeout, put_cnt});
      else n_pass++;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(1'b1, 1'b0, 1'b0);
      n_chk++;
      if (get !== 1'b1) $display("FAIL rst_mid_go1: got get=%b want 1", get);
      else n_pass++;
      step(1'b0, 1'b0, 1'b0);
      n_chk++;
      if (get !== 1'b1) $display("FAIL rst_mid_go2: got get=%b want 1", get);
      else n_pass++;
      step(1'b0, 1'b0, 1'b0);
      n_chk++;
      if (get !== 1'b0) $display("FAIL rst_mid_go3: got get=%b want 0", get);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      do_reset();
      clear_inputs();
      in_go[10]  = 1'b1;
      in_put[13] = 1'b1;
      in_put[15] = 1'b1;
      in_go[16]  = 1'b1;
      run(19);
      n_chk++;
      if ({o_done[16], o_get[17], o_get[18], o_get[19]} !== 4'b1110)
         $display("FAIL b2b_get: got done16,get17,18,19=%b want 1110",
                  {o_done[16], o_get[17], o_get[18], o_get[19]});
      else n_pass++;
      n_chk++;
      if (o_cnt[17] !== 4'd0) $display("FAIL b2b_cnt_clear: got %0d want 0", o_cnt[17]);
      else n_pass++;
   endtask

   task automatic test_random();
      logic g, s, p;
      logic [8:0] act, exp;
      int errs;
      errs = 0;
      do_reset();
      cyc = 0;
      for (int i = 0; i < 3000; i++) begin
         g = ($urandom_range(0, 99) < 35);
         s = ($urandom_range(0, 99) < 6);
         p = ($urandom_range(0, 99) < 30);
         step(g, s, p);
         act = {get, busy, done, aborted, timeout, put_cnt};
         exp = {exp_get, exp_busy, exp_done, exp_abort, exp_to, exp_cnt};
         n_chk++;
         if (act !== exp) begin
            errs++;
            if (errs <= 10)
               $display("FAIL random_cycle %0d: got get,busy,done,abort,to,cnt=%b want %b", i, act, exp);
         end else n_pass++;
      end
      go   = 1'b0;
      stop = 1'b0;
      put  = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      go    = 1'b0;
      stop  = 1'b0;
      put   = 1'b0;
      rst_n = 1'b0;
      model_reset();
      clear_inputs();
      test_reset();
      test_basic();
      test_idle_inputs();
      test_abort();
      test_stop_priority();
      test_watchdog();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
